// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply-divide unit with start/busy/done handshake,
// abort, and internal HI/LO result registers (one result bit per CALC cycle).
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_CALC = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               qsign_q, qsign_d;
  logic               rsign_q, rsign_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   quo_fin;
  logic [WIDTH-1:0]   rem_fin;
  logic               sgn_mode;

  // Magnitude of v when it is a signed operand; most-negative maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  assign sgn_mode = ~op_q[0];

  // acc holds {upper partial product, remaining multiplier bits}; the sum keeps its carry.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // acc holds {partial remainder, dividend/quotient}; a borrow means the trial subtract failed.
  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, dvs_q};
  assign div_next = {(div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], ~div_diff[WIDTH]};

  assign prod_fin = qsign_q ? -acc_q : acc_q;
  assign quo_fin  = qsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fin  = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // Next-state and datapath update for the whole FSM.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    qsign_d    = qsign_q;
    rsign_d    = rsign_q;
    dz_d       = dz_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PREP;
          busy_d  = 1'b1;
          op_d    = op;
          a_d     = a;
          b_d     = b;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_PREP: begin
        acc_d   = {{WIDTH{1'b0}}, mag(a_q, sgn_mode)};
        dvs_d   = mag(b_q, sgn_mode);
        cnt_d   = {CW{1'b0}};
        qsign_d = sgn_mode & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rsign_d = sgn_mode & a_q[WIDTH-1];
        dz_d    = op_q[1] && (b_q == {WIDTH{1'b0}});
        if (op_q[1] && (b_q == {WIDTH{1'b0}})) begin
          state_d = S_FIN;
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIN;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIN: begin
        state_d    = S_IDLE;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        div_zero_d = dz_q;
        if (dz_q) begin
          hi_d = a_q;
          lo_d = {WIDTH{1'b1}};
        end else if (op_q[1]) begin
          hi_d = rem_fin;
          lo_d = quo_fin;
        end else begin
          hi_d = prod_fin[2*WIDTH-1:WIDTH];
          lo_d = prod_fin[WIDTH-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Abort wins over everything, including FIN completion.
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
    end else begin
      state_d    = state_d;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= 2'd0;
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      acc_q      <= {(2*WIDTH){1'b0}};
      dvs_q      <= {WIDTH{1'b0}};
      cnt_q      <= {CW{1'b0}};
      qsign_q    <= 1'b0;
      rsign_q    <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      qsign_q    <= qsign_d;
      rsign_q    <= rsign_d;
      dz_q       <= dz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, control sequences and
// randomized operations compared against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        abort;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: plain 64-bit integer arithmetic; SV division truncates toward zero.
  task automatic model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                       output logic [31:0] ehi, output logic [31:0] elo, output logic edz);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa  = $signed(ma);
    sb  = $signed(mb);
    ua  = ma;
    ub  = mb;
    edz = 1'b0;
    p   = 64'd0;
    case (mop)
      2'd0: begin p = sa * sb; ehi = p[63:32]; elo = p[31:0]; end
      2'd1: begin p = ua * ub; ehi = p[63:32]; elo = p[31:0]; end
      default: begin
        if (mb == 32'd0) begin
          ehi = ma; elo = 32'hFFFF_FFFF; edz = 1'b1;
        end else if (mop == 2'd2) begin
          sq = sa / sb; sr = sa % sb;
          ehi = 32'(sr); elo = 32'(sq);
        end else begin
          ehi = 32'(ua % ub); elo = 32'(ua / ub);
        end
      end
    endcase
  endtask

  // Issue one operation, wait (bounded) for done and check timing and results.
  task automatic run_op(input string tag, input logic [1:0] top, input logic [31:0] ta,
                        input logic [31:0] tb, input bit with_abort);
    logic [31:0] ehi, elo;
    logic        edz;
    int          lat, bc, exp_lat;
    bit          seen;
    model(top, ta, tb, ehi, elo, edz);
    exp_lat = (top[1] && tb == 32'd0) ? 2 : 34;
    start = 1'b1; op = top; a = ta; b = tb; abort = with_abort;
    step();
    start = 1'b0; abort = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    chk({tag, "_done_low"}, {63'd0, done}, 64'd0);
    bc = busy ? 1 : 0;
    seen = 1'b0;
    lat = 0;
    for (int n = 1; n <= 60 && !seen; n++) begin
      step();
      if (done) begin
        seen = 1'b1;
        lat = n;
      end else if (busy) begin
        bc++;
      end
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_busy_cycles"}, 64'(bc), 64'(exp_lat));
      chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
      chk({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
      chk({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
      chk({tag, "_div_zero"}, {63'd0, div_zero}, {63'd0, edz});
    end
  endtask

  initial begin
    int e;
    bit any_done;
    logic [31:0] ra, rb;
    logic [1:0]  rop;

    rst = 1'b0; start = 1'b0; abort = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dz", {63'd0, div_zero}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b1;
    step();

    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    chk("div_neg_q_const", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
    run_op("div_minm1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_minm1_q_const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op("divu_zero", 2'd3, 32'h0000_0007, 32'h0000_0000, 1'b0);
    run_op("div_zero_s", 2'd2, 32'h8000_0001, 32'h0000_0000, 1'b0);
    run_op("start_abort_idle", 2'd3, 32'd1000, 32'd7, 1'b1);

    // Second start mid-operation must be ignored.
    start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd5;
    step(); e = 0;
    start = 1'b0;
    while (e < 9) begin step(); e++; end
    start = 1'b1; op = 2'd0; a = 32'd123; b = 32'd456;
    step(); e++;
    start = 1'b0;
    while (!done && e < 60) begin step(); e++; end
    chk("ignore_latency", 64'(e), 64'd34);
    chk("ignore_result", {hi, lo}, 64'd25);

    // Abort at cycle 20: busy drops, no done, hi/lo kept.
    start = 1'b1; op = 2'd1; a = 32'd6; b = 32'd7;
    step(); e = 0;
    start = 1'b0;
    while (e < 19) begin step(); e++; end
    abort = 1'b1;
    step(); e++;
    abort = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    any_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done || busy) any_done = 1'b1;
    end
    chk("abort_quiet", {63'd0, any_done}, 64'd0);
    chk("abort_hilo_kept", {hi, lo}, 64'd25);

    // Abort in IDLE has no effect.
    abort = 1'b1;
    repeat (3) step();
    abort = 1'b0;
    chk("idle_abort_busy", {63'd0, busy}, 64'd0);
    chk("idle_abort_hilo", {hi, lo}, 64'd25);

    // Reset mid-operation clears outputs immediately.
    start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd7;
    step(); e = 0;
    start = 1'b0;
    while (e < 14) begin step(); e++; end
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    run_op("after_rst", 2'd2, 32'd100, 32'd7, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 15));
        default: rb = rb;
      endcase
      run_op($sformatf("rnd%0d", i), rop, ra, rb, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
